sm_debug_ctrl: RTL

Run/halt/step controller for the schoolMIPS core. It drives sm_top clkEnable and owns the single debug read port (regAddr/regData). The port is shared between PC monitoring while the core runs (breakpoint compare) and register-file scan-out while halted. It sits beside sm_top and is driven by a host-side command source (UART/JTAG bridge or testbench).

---
 rtl/sm_debug_ctrl_pkg.sv | 33 +++
 rtl/sm_debug_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sm_debug_ctrl_pkg.sv
// Shared debug encodings for sm_debug_ctrl: 2-bit command opcodes and FSM state codes.
// The macros are the wire-level encodings; the package wraps them in typed enums.
`ifndef SM_DEBUG_VH
`define SM_DEBUG_VH
`define DBG_OP_RUN  2'd0
`define DBG_OP_HALT 2'd1
`define DBG_OP_STEP 2'd2
`define DBG_OP_SCAN 2'd3
`define DBG_ST_HALTED  2'd0
`define DBG_ST_RUNNING 2'd1
`define DBG_ST_STEP    2'd2
`define DBG_ST_SCAN    2'd3
`endif

package sm_debug_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RUN  = `DBG_OP_RUN,
    OP_HALT = `DBG_OP_HALT,
    OP_STEP = `DBG_OP_STEP,
    OP_SCAN = `DBG_OP_SCAN
  } dbgOp_t;

  typedef enum logic [1:0] {
    ST_HALTED  = `DBG_ST_HALTED,
    ST_RUNNING = `DBG_ST_RUNNING,
    ST_STEP    = `DBG_ST_STEP,
    ST_SCAN    = `DBG_ST_SCAN
  } dbgState_t;

  localparam int IDX_W = 5;

endpackage

// File: rtl/sm_debug_ctrl.sv
// Run/halt/step/scan controller for schoolMIPS. Drives sm_top clkEnable and time-shares
// the single debug read port between PC breakpoint monitoring and register scan-out.
module sm_debug_ctrl
  import sm_debug_ctrl_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b0,
  parameter int REG_COUNT    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  output logic        cpu_en,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic        dout_valid,
  output logic [4:0]  dout_idx,
  output logic [31:0] dout_data,
  input  logic        dout_ready,
  output logic        halted,
  output logic        bp_hit,
  output logic        scan_done,
  output logic        cmd_err,
  output logic [31:0] exec_cnt,
  output logic [1:0]  dbg_state
);

  // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready; a scan word
  // transfers on the edge where dout_valid && dout_ready. A valid, once raised, holds its
  // payload until it transfers.

  dbgState_t        state, stateNext;
  logic             skipBp;
  logic [IDX_W-1:0] idx;

  logic cmdFire;
  logic hit;
  logic lastIdx;
  logic runAccept;
  logic dropCmd;
  logic scanStart;
  logic scanAdvance;
  logic scanFinish;

  assign cmdFire = cmd_valid && cmd_ready;
  // The debug port is pointed at the PC (index 0) whenever the core runs.
  assign hit     = (state == ST_RUNNING) && bp_en && !skipBp && (reg_data == bp_addr);
  assign lastIdx = (idx == IDX_W'(REG_COUNT - 1));

  always_comb begin
    stateNext   = state;
    cmd_ready   = 1'b0;
    cpu_en      = 1'b0;
    reg_addr    = '0;
    dout_valid  = 1'b0;
    dout_idx    = '0;
    dout_data   = '0;
    runAccept   = 1'b0;
    dropCmd     = 1'b0;
    scanStart   = 1'b0;
    scanAdvance = 1'b0;
    scanFinish  = 1'b0;

    case (state)
      ST_HALTED: begin
        cmd_ready = 1'b1;
        if (cmdFire) begin
          case (cmd_op)
            `DBG_OP_RUN: begin
              stateNext = ST_RUNNING;
              runAccept = 1'b1;
            end
            `DBG_OP_STEP: stateNext = ST_STEP;
            `DBG_OP_SCAN: begin
              stateNext = ST_SCAN;
              scanStart = 1'b1;
            end
            default: stateNext = ST_HALTED;
          endcase
        end
      end

      ST_RUNNING: begin
        cmd_ready = 1'b1;
        // Gate the enable in the hit cycle so the instruction at bp_addr never retires.
        cpu_en    = !hit;
        if (hit) stateNext = ST_HALTED;
        if (cmdFire) begin
          if (cmd_op == `DBG_OP_HALT) stateNext = ST_HALTED;
          else                        dropCmd   = 1'b1;
        end
      end

      ST_STEP: begin
        cpu_en    = 1'b1;
        stateNext = ST_HALTED;
      end

      ST_SCAN: begin
        reg_addr   = idx;
        dout_valid = 1'b1;
        dout_idx   = idx;
        dout_data  = reg_data;
        if (dout_ready) begin
          if (lastIdx) begin
            stateNext  = ST_HALTED;
            scanFinish = 1'b1;
          end else begin
            scanAdvance = 1'b1;
          end
        end
      end

      default: stateNext = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN_ON_RESET ? ST_RUNNING : ST_HALTED;
      skipBp    <= 1'b1;
      idx       <= '0;
      exec_cnt  <= '0;
      bp_hit    <= 1'b0;
      scan_done <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      bp_hit    <= hit;
      scan_done <= scanFinish;
      cmd_err   <= dropCmd;
      if (cpu_en) exec_cnt <= exec_cnt + 32'd1;
      // Skip the compare for one cycle after RUN so resuming from a breakpoint makes progress.
      if (runAccept)                skipBp <= 1'b1;
      else if (state == ST_RUNNING) skipBp <= 1'b0;
      if (scanStart)        idx <= '0;
      else if (scanAdvance) idx <= idx + 1'b1;
    end
  end

  assign halted    = (state == ST_HALTED);
  assign dbg_state = state;

endmodule
